// File: rtl/unita_stack.sv
// ----------------------------------------------------------------------------
// unita_stack
//
// LIFO stack unit with push / pop / top and a sequential key search. Each
// operation is requested on a four-phase req/ack handshake: req is raised
// with op/din valid, the unit answers with a one-cycle ack, and req must be
// seen low before the next request is taken.
//
// The search walks the stack from the top entry down to slot 0. For every
// entry it presents (entry, key) on cmp_a/cmp_b to an external combinational
// comparator, waits one full clock for it to settle, then samples cmp_ne.
// The first equal entry from the top wins.
//
// Build option:
//   UNITA_STACK_SEARCH_EN  defined   : op=11 performs the search.
//                          undefined : search hardware is not built,
//                                      cmp_a/cmp_b are tied to 0, cmp_ne is
//                                      ignored and op=11 is refused (err=1).
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-high reset
//   req      request, held high until ack, then dropped
//   op       00 push, 01 pop, 10 top, 11 search (sampled with req)
//   din      push data / search key (sampled with req)
//   ack      one-cycle completion pulse
//   dout     popped, top or matched entry
//   found    search hit
//   index    slot of the matched entry (0 = bottom)
//   err      operation refused (overflow, underflow, empty search,
//            disabled search)
//   count    current occupancy
//   full     count == DEPTH
//   empty    count == 0
//   cmp_a    registered comparator input: stored entry
//   cmp_b    registered comparator input: search key
//   cmp_ne   comparator result, 0 = equal, 1 = different
// ----------------------------------------------------------------------------
module unita_stack #(
   parameter int N     = 16,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req,
   input  logic [1:0]    op,
   input  logic [N-1:0]  din,
   output logic          ack,
   output logic [N-1:0]  dout,
   output logic          found,
   output logic [AW-1:0] index,
   output logic          err,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic [N-1:0]  cmp_a,
   output logic [N-1:0]  cmp_b,
   input  logic          cmp_ne
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRES,
      S_CHK,
      S_ACK,
      S_REL
   } state_t;

   localparam logic [1:0]  OP_PUSH  = 2'b00;
   localparam logic [1:0]  OP_POP   = 2'b01;
   localparam logic [1:0]  OP_TOP   = 2'b10;
   localparam logic [1:0]  OP_SRCH  = 2'b11;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t        state;
   state_t        state_nx;

   logic [N-1:0]  mem [DEPTH];
   logic [AW:0]   sp;        // next free slot == occupancy
   logic [AW:0]   sp_dec;
   logic [AW-1:0] top_slot;  // slot of the current top entry
   logic          start;     // request accepted this cycle
   logic          search_go; // accepted request starts a real search walk

   assign sp_dec   = sp - 1'b1;
   assign top_slot = sp_dec[AW-1:0];

   assign count = sp;
   assign full  = (sp == FULL_CNT);
   assign empty = (sp == '0);

   assign start = (state == S_IDLE) && req;

`ifdef UNITA_STACK_SEARCH_EN
   logic [AW-1:0] ptr;       // slot currently being compared
   logic [N-1:0]  key;

   assign search_go = start && (op == OP_SRCH) && !empty;
`else
   logic unused_cmp_ne;

   assign search_go     = 1'b0;
   assign unused_cmp_ne = cmp_ne;
   assign cmp_a         = '0;
   assign cmp_b         = '0;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         state <= state_nx;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nx unassigned
      // (which would infer a latch).
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (req) begin
               state_nx = search_go ? S_PRES : S_ACK;
            end
         end
`ifdef UNITA_STACK_SEARCH_EN
         S_PRES: begin
            state_nx = S_CHK;
         end
         S_CHK: begin
            // Stop on the first hit, or after slot 0 has been compared.
            if (!cmp_ne || (ptr == '0)) begin
               state_nx = S_ACK;
            end else begin
               state_nx = S_PRES;
            end
         end
`endif
         S_ACK: begin
            state_nx = S_REL;
         end
         S_REL: begin
            // A req still high here belongs to the finished operation.
            if (!req) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      ack = (state == S_ACK);
   end

   // -------------------------------------------------------------------------
   // Entry storage
   // -------------------------------------------------------------------------
   // NOTE: the storage array has no reset; occupancy is tracked by sp, so
   // stale contents are never observable and the array can map to RAM.
   always_ff @(posedge clock) begin
      if (start && (op == OP_PUSH) && !full) begin
         mem[sp[AW-1:0]] <= din;
      end
   end

   // -------------------------------------------------------------------------
   // Stack pointer and result registers. Results change only on the edge that
   // enters ACK and hold until the next operation completes.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp    <= '0;
         dout  <= '0;
         found <= 1'b0;
         index <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  case (op)
                     OP_PUSH: begin
                        found <= 1'b0;
                        if (full) begin
                           err <= 1'b1;
                        end else begin
                           err <= 1'b0;
                           sp  <= sp + 1'b1;
                        end
                     end
                     OP_POP: begin
                        found <= 1'b0;
                        if (empty) begin
                           err <= 1'b1;
                        end else begin
                           err  <= 1'b0;
                           dout <= mem[top_slot];
                           sp   <= sp_dec;
                        end
                     end
                     OP_TOP: begin
                        found <= 1'b0;
                        if (empty) begin
                           err <= 1'b1;
                        end else begin
                           err  <= 1'b0;
                           dout <= mem[top_slot];
                        end
                     end
                     default: begin
`ifdef UNITA_STACK_SEARCH_EN
                        // A non-empty search reports from CHK instead.
                        if (empty) begin
                           err   <= 1'b1;
                           found <= 1'b0;
                        end
`else
                        err   <= 1'b1;
                        found <= 1'b0;
`endif
                     end
                  endcase
               end
            end
`ifdef UNITA_STACK_SEARCH_EN
            S_CHK: begin
               if (!cmp_ne) begin
                  found <= 1'b1;
                  index <= ptr;
                  dout  <= mem[ptr];
                  err   <= 1'b0;
               end else if (ptr == '0) begin
                  found <= 1'b0;
                  err   <= 1'b0;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

`ifdef UNITA_STACK_SEARCH_EN
   // -------------------------------------------------------------------------
   // Search walker. cmp_a/cmp_b are loaded in PRES and held through CHK, so
   // the comparator has a full clock period to settle before cmp_ne is used.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr   <= '0;
         key   <= '0;
         cmp_a <= '0;
         cmp_b <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  key <= din;
                  ptr <= top_slot;
               end
            end
            S_PRES: begin
               cmp_a <= mem[ptr];
               cmp_b <= key;
            end
            S_CHK: begin
               if (cmp_ne && (ptr != '0)) begin
                  ptr <= ptr - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end
`endif

endmodule
